// File: rtl/commit_trace_fifo.sv
// Retire-trace capture: logs {pc, inst[, seq]} each time pc changes, buffered in a FWFT FIFO.
// Optional per-entry retire sequence number enabled by defining TRACE_SEQ_EN.
module commit_trace_fifo #(
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int DROP_W = 16
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [31:0]       pc,
    input  logic [31:0]       inst,
    output logic              tr_valid,
    input  logic              tr_ready,
    output logic [31:0]       tr_pc,
    output logic [31:0]       tr_inst,
    output logic [15:0]       tr_seq,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

`ifdef TRACE_SEQ_EN
    localparam int EW = 80;
`else
    localparam int EW = 64;
`endif

    logic [EW-1:0]  mem [DEPTH];
    logic [EW-1:0]  head;
    logic [EW-1:0]  wr_entry;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           primed;
    logic [31:0]    last_pc;
    logic           retire;
    logic           full;
    logic           pop;
    logic           push;
    logic           drop;

    assign retire = !primed || (pc != last_pc);
    assign full   = (count == (AW+1)'(DEPTH));
    assign pop    = tr_valid && tr_ready;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign push   = retire && (!full || pop);
    assign drop   = retire && full && !pop;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            primed  <= 1'b0;
            last_pc <= '0;
        end else if (retire) begin
            primed  <= 1'b1;
            last_pc <= pc;
        end
    end

`ifdef TRACE_SEQ_EN
    logic [15:0] seq_cnt;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            seq_cnt <= '0;
        else if (retire)
            seq_cnt <= seq_cnt + 16'd1;
    end

    assign wr_entry = {pc, inst, seq_cnt};
`else
    assign wr_entry = {pc, inst};
`endif

    always_ff @(posedge clk_in) begin
        if (push)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign head     = mem[rd_ptr];
    assign tr_valid = (count != '0);
    assign level    = count;

    // Head fields are forced to zero while empty so reset presents all-zero outputs.
`ifdef TRACE_SEQ_EN
    assign tr_pc   = tr_valid ? head[79:48] : '0;
    assign tr_inst = tr_valid ? head[47:16] : '0;
    assign tr_seq  = tr_valid ? head[15:0]  : '0;
`else
    assign tr_pc   = tr_valid ? head[63:32] : '0;
    assign tr_inst = tr_valid ? head[31:0]  : '0;
    assign tr_seq  = 16'h0000;
`endif

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Scoreboard bench for commit_trace_fifo: a behavioural queue model predicts every record.
module tb_commit_trace_fifo;

    localparam int DEPTH  = 8;
    localparam int AW     = 3;
    localparam int DROP_W = 16;

    logic              clk_in = 1'b0;
    logic              reset;
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic              tr_valid;
    logic              tr_ready;
    logic [31:0]       tr_pc;
    logic [31:0]       tr_inst;
    logic [15:0]       tr_seq;
    logic [AW:0]       level;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    commit_trace_fifo #(.DEPTH(DEPTH), .AW(AW), .DROP_W(DROP_W)) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .pc       (pc),
        .inst     (inst),
        .tr_valid (tr_valid),
        .tr_ready (tr_ready),
        .tr_pc    (tr_pc),
        .tr_inst  (tr_inst),
        .tr_seq   (tr_seq),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [15:0] seq;
    } rec_t;

    rec_t        sb[$];
    bit          m_primed;
    logic [31:0] m_last;
    logic [15:0] m_seq;
    int          m_drop;
    bit          m_ovf;
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [15:0] exp_seq(input logic [15:0] s);
`ifdef TRACE_SEQ_EN
        return s;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic model_clear();
        sb.delete();
        m_primed = 0;
        m_last   = '0;
        m_seq    = '0;
        m_drop   = 0;
        m_ovf    = 0;
    endtask

    task automatic drive(input logic [31:0] p);
        pc   = p;
        inst = p ^ 32'h2000_0a5a;
    endtask

    // One clock: check/pop head, predict capture, advance, check occupancy/status.
    task automatic tick(input string tag);
        rec_t h;
        rec_t n;
        if (sb.size() > 0) begin
            h = sb[0];
            checks++;
            if (tr_valid !== 1'b1) begin
                failures++;
                $display("FAIL %s valid: got %b want 1", tag, tr_valid);
            end
            checks++;
            if ({tr_pc, tr_inst, tr_seq} !== {h.pc, h.inst, h.seq}) begin
                failures++;
                $display("FAIL %s head: got pc=%h inst=%h seq=%0d want pc=%h inst=%h seq=%0d",
                         tag, tr_pc, tr_inst, tr_seq, h.pc, h.inst, h.seq);
            end
            if (tr_ready) void'(sb.pop_front());
        end else begin
            checks++;
            if (tr_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s valid: got %b want 0", tag, tr_valid);
            end
        end
        if (!m_primed || pc != m_last) begin
            m_primed = 1;
            m_last   = pc;
            if (sb.size() < DEPTH) begin
                n.pc   = pc;
                n.inst = inst;
                n.seq  = exp_seq(m_seq);
                sb.push_back(n);
            end else begin
                m_ovf = 1;
                if (m_drop != 65535) m_drop++;
            end
            m_seq = m_seq + 16'd1;
        end
        @(posedge clk_in);
        #1;
        checks++;
        if ({level, overflow, drop_cnt} !== {4'(sb.size()), m_ovf, 16'(m_drop)}) begin
            failures++;
            $display("FAIL %s status: got level=%0d ovf=%b drop=%0d want level=%0d ovf=%b drop=%0d",
                     tag, level, overflow, drop_cnt, sb.size(), m_ovf, m_drop);
        end
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        #2;
        checks++;
        if ({tr_valid, level, overflow, drop_cnt} !== 22'd0) begin
            failures++;
            $display("FAIL %s async_reset: got valid=%b level=%0d ovf=%b drop=%0d want all 0",
                     tag, tr_valid, level, overflow, drop_cnt);
        end
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        tr_ready = 1'b0;
        drive(32'h0040_0000);
        model_clear();
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if ({tr_valid, level, overflow, drop_cnt, tr_pc, tr_inst, tr_seq} !== 102'd0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b level=%0d ovf=%b drop=%0d pc=%h inst=%h seq=%0d want all 0",
                     tr_valid, level, overflow, drop_cnt, tr_pc, tr_inst, tr_seq);
        end
        reset = 1'b0;
        tick("prime");
        tick("prime_hold");
        tick("prime_hold2");
        checks++;
        if (level !== 4'd1) begin
            failures++;
            $display("FAIL prime_level: got %0d want 1", level);
        end
    endtask

    task automatic test_stream();
        tr_ready = 1'b1;
        drive(32'h0040_0004);
        tick("stream_a");
        drive(32'h0040_0008);
        tick("stream_b");
        tick("stream_c");
        tick("stream_d");
    endtask

    task automatic test_overflow();
        apply_reset("ovf");
        tr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(32'h0040_1000 + 32'(i) * 4);
            tick("ovf_fill");
        end
        checks++;
        if ({level, overflow, drop_cnt} !== {4'd8, 1'b1, 16'd2}) begin
            failures++;
            $display("FAIL ovf_status: got level=%0d ovf=%b drop=%0d want 8 1 2",
                     level, overflow, drop_cnt);
        end
        tr_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick("ovf_drain");
        drive(32'h0040_2000);
        tr_ready = 1'b0;
        tick("ovf_next");
        tick("ovf_next_hold");
        checks++;
        if (tr_seq !== exp_seq(16'd10)) begin
            failures++;
            $display("FAIL ovf_next_seq: got %0d want %0d", tr_seq, exp_seq(16'd10));
        end
    endtask

    task automatic test_full_push_pop();
        tr_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(32'h0040_3000 + 32'(i) * 4);
            tick("full_fill");
        end
        tr_ready = 1'b1;
        drive(32'h0040_3100);
        tick("full_pushpop");
        tr_ready = 1'b0;
        checks++;
        if ({level, drop_cnt} !== {4'd8, 16'd2}) begin
            failures++;
            $display("FAIL full_pushpop: got level=%0d drop=%0d want 8 2", level, drop_cnt);
        end
    endtask

    task automatic test_hold_self_jump();
        tr_ready = 1'b1;
        tick("hold_pop");
        tr_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick("hold");
        inst = 32'h0810_0c40;
        tick("self_jump");
        tick("self_jump2");
        checks++;
        if (level !== 4'd7) begin
            failures++;
            $display("FAIL hold_level: got %0d want 7", level);
        end
    endtask

    task automatic test_reset_mid();
        tr_ready = 1'b1;
        repeat (2) tick("mid_drain");
        tr_ready = 1'b0;
        checks++;
        if ({level, overflow} !== {4'd5, 1'b1}) begin
            failures++;
            $display("FAIL mid_pre: got level=%0d ovf=%b want 5 1", level, overflow);
        end
        apply_reset("mid");
        tick("mid_prime");
        tick("mid_prime_hold");
        checks++;
        if ({tr_valid, tr_seq} !== {1'b1, 16'd0}) begin
            failures++;
            $display("FAIL mid_first_seq: got valid=%b seq=%0d want 1 0", tr_valid, tr_seq);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_overflow();
        test_full_push_pop();
        test_hold_self_jump();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
